// File: rtl/fir_decim.sv
// Decimating single-MAC FIR low-pass stage: reads DECIMATION samples from the input FIFO,
// then runs TAPS multiply-accumulate cycles and writes one Q10-dequantized result.
module fir_decim #(
  parameter int TAPS       = 32,
  parameter int DECIMATION = 8,
  parameter int DATA_SIZE  = 32,
  parameter int BITS       = 10,
  parameter logic [0:TAPS-1][DATA_SIZE-1:0] COEFFS = '0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_SIZE-1:0] x_in,
  output logic                 x_rd_en,
  input  logic                 x_empty,
  output logic [DATA_SIZE-1:0] y_out,
  input  logic                 y_out_full,
  output logic                 y_wr_en
);

  localparam int CW = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;
  localparam int KW = $clog2(TAPS);
  localparam int PW = 2 * DATA_SIZE;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    MAC   = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_SIZE-1:0]  x_q [TAPS];
  logic [DATA_SIZE-1:0]  x_d [TAPS];
  logic [DATA_SIZE-1:0]  acc_q, acc_d;
  logic [DATA_SIZE-1:0]  y_q, y_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [KW-1:0]         k_q, k_d;
  logic signed [DATA_SIZE-1:0] coef_s, samp_s;
  logic signed [PW-1:0]  prod_s;
  logic [DATA_SIZE-1:0]  term_s;

  // Divide by 2^BITS rounding toward zero, then keep the low DATA_SIZE bits.
  function automatic logic [DATA_SIZE-1:0] dequant(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] m;
    if (p < 0) begin
      m = -p;
      m = m >>> BITS;
      m = -m;
    end else begin
      m = p >>> BITS;
    end
    return m[DATA_SIZE-1:0];
  endfunction

  // Strobes are suppressed while reset is held so nothing is consumed or emitted.
  assign x_rd_en = reset & (state_q == LOAD) & ~x_empty;
  assign y_wr_en = reset & (state_q == WRITE) & ~y_out_full;
  assign y_out   = y_q;

  // Next-state, datapath and tap-product logic.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    y_d     = y_q;
    coef_s  = $signed(COEFFS[k_q]);
    samp_s  = $signed(x_q[k_q]);
    prod_s  = PW'(coef_s) * PW'(samp_s);
    term_s  = dequant(prod_s);
    case (state_q)
      LOAD: begin
        if (x_rd_en) begin
          x_d[0] = x_in;
          for (int i = 1; i < TAPS; i++) begin
            x_d[i] = x_q[i-1];
          end
          if (cnt_q == CW'(DECIMATION - 1)) begin
            cnt_d   = '0;
            acc_d   = '0;
            k_d     = '0;
            state_d = MAC;
          end else begin
            cnt_d   = cnt_q + CW'(1);
          end
        end else begin
          state_d = LOAD;
        end
      end
      MAC: begin
        acc_d = acc_q + term_s;
        if (k_q == KW'(TAPS - 1)) begin
          y_d     = acc_q + term_s;
          k_d     = '0;
          state_d = WRITE;
        end else begin
          k_d     = k_q + KW'(1);
        end
      end
      WRITE: begin
        if (y_wr_en) begin
          state_d = LOAD;
        end else begin
          state_d = WRITE;
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial result.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= LOAD;
      for (int i = 0; i < TAPS; i++) begin
        x_q[i] <= '0;
      end
      acc_q <= '0;
      y_q   <= '0;
      cnt_q <= '0;
      k_q   <= '0;
    end else begin
      state_q <= state_d;
      for (int i = 0; i < TAPS; i++) begin
        x_q[i] <= x_d[i];
      end
      acc_q <= acc_d;
      y_q   <= y_d;
      cnt_q <= cnt_d;
      k_q   <= k_d;
    end
  end

endmodule

// File: tb/tb_fir_decim.sv
// Scoreboard bench for fir_decim: a FIFO-emulating driver, an arithmetic reference model
// feeding an expected-output queue, and an independent monitor popping it on each write.
module tb_fir_decim;

  localparam int TAPS = 32;
  localparam int DEC  = 8;
  localparam int DW   = 32;
  localparam int BITS = 10;

  function automatic logic [0:TAPS-1][DW-1:0] ramp_coeffs();
    logic [0:TAPS-1][DW-1:0] c;
    for (int k = 0; k < TAPS; k++) c[k] = DW'(k + 1);
    return c;
  endfunction

  localparam logic [0:TAPS-1][DW-1:0] C  = ramp_coeffs();
  localparam logic [0:1][DW-1:0]      RC = {32'hFFFF_FFFF, 32'h0000_0000};

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic [DW-1:0] x_in, y_out;
  logic x_empty, x_rd_en, y_out_full, y_wr_en;
  logic [DW-1:0] r_x_in, r_y_out;
  logic r_x_empty, r_x_rd_en, r_full, r_y_wr_en;

  fir_decim #(.TAPS(TAPS), .DECIMATION(DEC), .DATA_SIZE(DW), .BITS(BITS), .COEFFS(C)) dut (
    .clock(clock), .reset(reset), .x_in(x_in), .x_rd_en(x_rd_en), .x_empty(x_empty),
    .y_out(y_out), .y_out_full(y_out_full), .y_wr_en(y_wr_en));

  fir_decim #(.TAPS(2), .DECIMATION(1), .DATA_SIZE(DW), .BITS(BITS), .COEFFS(RC)) dut_rnd (
    .clock(clock), .reset(reset), .x_in(r_x_in), .x_rd_en(r_x_rd_en), .x_empty(r_x_empty),
    .y_out(r_y_out), .y_out_full(r_full), .y_wr_en(r_y_wr_en));

  int n_checks = 0;
  int n_pass   = 0;
  int rd_cnt   = 0;
  int n_sent   = 0;
  int full_mode = 0;   // 0: never full, 1: always full, 2: random
  bit starve   = 1'b0;
  bit auto_exp = 1'b0;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  longint        hist[$];   // hist[0] is the newest sample read by the filter

  task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d (0x%h), wanted %0d (0x%h)", name, $signed(act), act, $signed(req), req);
  endtask

  // Reference: sum over taps of trunc-toward-zero(C[k]*x[n-k] / 2^BITS), wrapped to DW bits.
  function automatic logic [DW-1:0] model_out();
    longint sum = 0;
    longint c;
    for (int k = 0; k < TAPS; k++) begin
      if (k < hist.size()) begin
        c = longint'($signed(C[k]));
        sum += (c * hist[k]) / (longint'(1) << BITS);
      end
    end
    return sum[DW-1:0];
  endfunction

  task automatic send(logic [DW-1:0] v);
    longint sv = longint'($signed(v));
    fifo_q.push_back(v);
    hist.push_front(sv);
    if (hist.size() > TAPS) void'(hist.pop_back());
    n_sent++;
    if (auto_exp && (n_sent % DEC == 0)) exp_q.push_back(model_out());
  endtask

  task automatic clear_model();
    fifo_q.delete();
    exp_q.delete();
    hist.delete();
    n_sent = 0;
  endtask

  task automatic push_impulse_expect();
    exp_q.push_back(32'd8);  exp_q.push_back(32'd16);
    exp_q.push_back(32'd24); exp_q.push_back(32'd32);
    for (int i = 0; i < 4; i++) exp_q.push_back(32'd0);
  endtask

  task automatic wait_reads(int target, int budget);
    int c = 0;
    while (rd_cnt < target && c < budget) begin
      @(negedge clock);
      c++;
    end
    if (rd_cnt < target) begin
      n_checks++;
      $display("FAIL read_timeout: got %0d reads, wanted %0d", rd_cnt, target);
    end
  endtask

  task automatic drain(int budget);
    int c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      @(negedge clock);
      c++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain_timeout: got %0d outputs still pending, wanted 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic round_case(int v, int req);
    int c = 0;
    r_x_in = DW'(v);
    r_x_empty = 1'b0;
    @(negedge clock);
    while (!r_x_rd_en && c < 20) begin @(negedge clock); c++; end
    @(posedge clock);
    #1 r_x_empty = 1'b1;
    c = 0;
    @(negedge clock);
    while (!r_y_wr_en && c < 20) begin @(negedge clock); c++; end
    check("round_y_out", r_y_wr_en ? r_y_out : 32'hDEAD_BEEF, DW'(req));
  endtask

  // FIFO emulation: pop on each accepted read, then present the next sample and full flag.
  initial begin
    x_empty = 1'b1;
    x_in = '0;
    y_out_full = 1'b0;
    forever begin
      @(posedge clock);
      if (x_rd_en && !x_empty) begin
        void'(fifo_q.pop_front());
        rd_cnt++;
      end
      #1;
      x_empty = (fifo_q.size() == 0) || (starve && $urandom_range(0, 1) == 0);
      x_in = (fifo_q.size() != 0) ? fifo_q[0] : DW'($urandom);
      y_out_full = (full_mode == 1) || (full_mode == 2 && $urandom_range(0, 2) == 0);
    end
  end

  // Monitor: compare every write against the scoreboard and watch strobe rules.
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        if (x_empty) check("no_read_when_empty", DW'(x_rd_en), 32'd0);
        if (y_wr_en) begin
          check("wr_rd_exclusive", DW'(x_rd_en), 32'd0);
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_write: got y_out=%0d, wanted no write", $signed(y_out));
          end else begin
            check("y_out", y_out, exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, wanted completion");
    $fatal(1, "timeout");
  end

  initial begin
    int target;
    r_x_in = '0;
    r_x_empty = 1'b1;
    r_full = 1'b0;

    // Reset state with a sample already waiting: no strobes, output cleared.
    push_impulse_expect();
    send(32'd1024);
    repeat (3) @(negedge clock);
    check("rst_y_out", y_out, 32'd0);
    check("rst_x_rd_en", DW'(x_rd_en), 32'd0);
    check("rst_y_wr_en", DW'(y_wr_en), 32'd0);
    reset = 1'b1;

    // Impulse.
    for (int i = 0; i < 63; i++) send(32'd0);
    drain(4000);

    // DC ramp-up on the zero history.
    exp_q.push_back(32'd36);  exp_q.push_back(32'd136);
    exp_q.push_back(32'd300);
    for (int i = 0; i < 3; i++) exp_q.push_back(32'd528);
    for (int i = 0; i < 6 * DEC; i++) send(32'd1024);
    drain(4000);

    // Backpressure in WRITE with further input waiting.
    auto_exp = 1'b1;
    full_mode = 1;
    target = rd_cnt + DEC;
    for (int i = 0; i < 2 * DEC; i++) send(32'd1024);
    wait_reads(target, 200);
    repeat (TAPS + 3) @(negedge clock);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      check("bp_no_write", DW'(y_wr_en), 32'd0);
      check("bp_no_read", DW'(x_rd_en), 32'd0);
      check("bp_y_stable", y_out, 32'd528);
    end
    full_mode = 0;
    @(negedge clock);
    check("bp_write_on_release", DW'(y_wr_en), 32'd1);
    @(negedge clock);
    check("bp_single_write", DW'(y_wr_en), 32'd0);
    drain(2000);

    // Starvation and random backpressure against the model.
    starve = 1'b1;
    full_mode = 2;
    for (int i = 0; i < 12 * DEC; i++) begin
      if (i % 3 == 0) send(DW'($urandom));
      else send(DW'(int'($urandom_range(0, 2097151)) - 1048576));
    end
    drain(20000);
    starve = 1'b0;
    full_mode = 0;

    // Reset in the middle of MAC, then the impulse must reproduce exactly.
    target = rd_cnt + DEC;
    for (int i = 0; i < DEC; i++) send(DW'(int'($urandom_range(1, 65535))));
    wait_reads(target, 200);
    repeat (10) @(negedge clock);
    reset = 1'b0;
    clear_model();
    @(negedge clock);
    check("midrst_y_out", y_out, 32'd0);
    check("midrst_y_wr_en", DW'(y_wr_en), 32'd0);
    check("midrst_x_rd_en", DW'(x_rd_en), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    auto_exp = 1'b0;
    push_impulse_expect();
    send(32'd1024);
    for (int i = 0; i < 63; i++) send(32'd0);
    drain(4000);

    // Rounding toward zero with coefficients {-1, 0}.
    round_case(1, 0);
    round_case(-2048, 2);
    round_case(3000, -2);
    round_case(-1023, 0);
    round_case(1024, -1);

    repeat (5) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fir_decim.md
# fir_decim

Decimating real-valued FIR low-pass stage of the FM audio path. It consumes demodulated samples from an input FIFO, filters them with a TAPS-long Q10 coefficient set, and emits one filtered sample per DECIMATION inputs into the output FIFO. That FIFO feeds the de-emphasis IIR stage. It is a single-MAC, time-multiplexed implementation.

## Interface
- TAPS, 32, number of filter taps (≥2)
- DECIMATION, 8, input samples consumed per output sample (≥1)
- DATA_SIZE, 32, sample/coefficient width, signed two's complement
- BITS, 10, fixed-point fraction bits (Q10)
- COEFFS, all zeros, packed array [0:TAPS-1][DATA_SIZE-1:0]; COEFFS[k] multiplies the sample k positions old
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- x_in  in  DATA_SIZE  input FIFO data, valid while x_empty=0
- x_rd_en  out  1  input FIFO read strobe; combinational
- x_empty  in  1  input FIFO empty
- y_out  out  DATA_SIZE  output sample; registered
- y_out_full  in  1  output FIFO full
- y_wr_en  out  1  output FIFO write strobe; combinational

## Operation
- Shift register x[0:TAPS-1], where x[0] is the newest sample. The block also has a signed accumulator acc, a decimation counter cnt of 0..DECIMATION-1, and a tap index k of 0..TAPS-1.
- The FSM has three states: LOAD, MAC and WRITE.
- LOAD, read rules:
  - x_rd_en = (x_empty==0).
  - On a read, shift x[1:TAPS-1] ← x[0:TAPS-2], load x[0] ← x_in, and set cnt ← (cnt+1) mod DECIMATION.
  - If cnt==DECIMATION-1 at the read, clear acc and k, then go to MAC. Otherwise stay in LOAD.
  - If x_empty=1, hold everything.
- MAC, one tap per cycle:
  - Form the full 2·DATA_SIZE signed product COEFFS[k]·x[k].
  - Dequantize: divide by 2^BITS, rounding toward zero (negative values are negated, arithmetically shifted, then negated back). Truncate the result to DATA_SIZE.
  - Update acc ← acc + dequantized term, wrapping modulo 2^DATA_SIZE.
  - Increment k. After k==TAPS-1, go to WRITE.
  - No reads occur in MAC.
- WRITE:
  - y_wr_en = (y_out_full==0), and y_out presents the final acc.
  - When the write occurs, go to LOAD.
  - While full, stay in WRITE: y_out is stable, y_wr_en=0 and x_rd_en=0.
- y_out is a register loaded from acc on the final MAC cycle. It holds its value until the next output.
- Reset, asserted at any time including mid-MAC or in WRITE:
  - state ← LOAD; x, acc, cnt, k and y_out ← 0.
  - x_rd_en=0 and y_wr_en=0 while reset is asserted.
  - Any partial computation is discarded and no write is emitted.
- The history in x persists across outputs; only a reset clears it.

## Timing
- Reads: at most one per cycle. A read happens in the same cycle that x_rd_en is high, with x_in sampled at that edge.
- Per output, with no stalls: DECIMATION read cycles, then TAPS MAC cycles, then 1 WRITE cycle. With the defaults this is 8+32+1 = 41 cycles.
- The y_wr_en pulse is exactly one cycle per output when the output FIFO is not full. It is never asserted in the same cycle as x_rd_en.
- The first output appears after the first DECIMATION samples have been read. Unread taps contribute 0.
- Simultaneous x_empty=0 and y_out_full=1 in WRITE: no read occurs; the block waits in WRITE.

## Test plan
- Impulse, with DECIMATION=8, TAPS=32 and COEFFS[k]=k+1: feed 1024 followed by zeros. Outputs must be 8, 16, 24, 32 (that is, COEFFS[7], COEFFS[15], COEFFS[23], COEFFS[31]), then 0 thereafter.
- DC, with all inputs 1024 and the same COEFFS: every output from the 4th onward equals the sum of COEFFS, 528. The first three outputs are 36, 136 and 300.
- Rounding, with DECIMATION=1, TAPS=2 and COEFFS={-1,0}: input x=1 gives output 0, not -1. Input x=-2048 gives output 2.
- Backpressure: hold y_out_full=1 for 20 cycles during WRITE. y_wr_en stays 0, y_out is unchanged and x_rd_en stays 0. Exactly one write occurs in the cycle full drops.
- Input starvation: toggle x_empty randomly. The output stream must match a golden model bit-exactly, and there are no reads while x_empty=1.
- Reset mid-MAC: drop reset at MAC k=10. All outputs are 0 immediately and state is LOAD. Re-running the impulse test reproduces its results exactly.
